// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter: FSM encodings and default widths.
// Imported by the interface, the timer and the arbiter top.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_LOAD = 2'b01,
    ARB_RUN  = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_e;

  localparam int TW_DEFAULT    = 4;
  localparam int N_REQ_DEFAULT = 2;

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bus of the timer arbiter: request levels and intervals in,
// grant/done/busy back to the controllers.
interface timer_arbiter_if
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int TW    = TW_DEFAULT
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*TW-1:0] req_init;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic                busy;

  modport master (output req, req_init, input grant, done, busy);
  modport slave  (input req, req_init, output grant, done, busy);
endinterface

// File: rtl/timer.sv
// Shared 4-bit down-counter used by the traffic-light controllers.
// Load has priority over enable; decrement saturates at zero.
module timer
  import timer_arbiter_pkg::*;
#(
  parameter int TW = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [TW-1:0] init,
  output logic [TW-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= init;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ.
module timer_arbiter_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] winner_oh,
  output logic [IW-1:0]    winner_idx,
  output logic             valid
);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int s;
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!valid && req[s]) begin
        valid        = 1'b1;
        winner_oh[s] = 1'b1;
        winner_idx   = IW'(s);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of the shared timer: grants one requester, loads its
// interval, runs the count and pulses done to the owner on expiry.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int TW    = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  timer_arbiter_if.slave bus,
  output logic          timer_en,
  output logic          timer_load,
  output logic [TW-1:0] timer_init,
  input  logic [TW-1:0] timer_out
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state, state_d;
  logic [IW-1:0]    ptr, ptr_d;
  logic [IW-1:0]    owner, owner_d;
  logic [IW-1:0]    owner_next;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [TW-1:0]    init_q, init_d;
  logic             busy_q, en_q, load_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  timer_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req        (bus.req),
    .ptr        (ptr),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign owner_next = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    grant_d = grant_q;
    done_d  = '0;
    init_d  = init_q;
    unique case (state)
      ARB_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d = ARB_LOAD;
          grant_d = pick_oh;
          owner_d = pick_idx;
          init_d  = bus.req_init[int'(pick_idx)*TW +: TW];
        end
      end
      ARB_LOAD: state_d = ARB_RUN;
      ARB_RUN: begin
        // Expiry is tested first so it wins over a same-cycle abort.
        if (timer_out == '0) begin
          state_d        = ARB_DONE;
          grant_d        = '0;
          done_d[owner]  = 1'b1;
          ptr_d          = owner_next;
        end else if (!bus.req[owner]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = owner_next;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      init_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      init_q  <= init_d;
      busy_q  <= (state_d != ARB_IDLE);
      en_q    <= (state_d == ARB_RUN);
      load_q  <= (state_d == ARB_LOAD);
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign timer_en   = en_q;
  assign timer_load = load_q;
  assign timer_init = init_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter driving a real timer; cycle numbers in the
// tags count from the edge that samples the request (LOAD = cycle 1).
module tb_timer_arbiter;
  localparam int N_REQ = 2;
  localparam int TW    = 4;

  logic          clk;
  logic          rst;
  logic          timer_en, timer_load;
  logic [TW-1:0] timer_init, timer_out;

  int n_checks = 0;
  int n_errors = 0;

  timer_arbiter_if #(.N_REQ(N_REQ), .TW(TW)) bus ();

  timer_arbiter #(.N_REQ(N_REQ), .TW(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .timer_en   (timer_en),
    .timer_load (timer_load),
    .timer_init (timer_init),
    .timer_out  (timer_out)
  );

  timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (timer_en),
    .load  (timer_load),
    .init  (timer_init),
    .count (timer_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_en"},    32'(timer_en),  32'd0);
    check({tag, "_load"},  32'(timer_load), 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    bus.req      = '0;
    bus.req_init = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_init", 32'(timer_init), 32'd0);
    rst = 1'b1;
    step();
    check_idle("post_rst");

    // Single grant: requester 0, interval 5
    bus.req_init = {4'd0, 4'd5};
    bus.req      = 2'b01;
    step();
    check("single_c1_grant", 32'(bus.grant), 32'd1);
    check("single_c1_load",  32'(timer_load), 32'd1);
    check("single_c1_init",  32'(timer_init), 32'd5);
    check("single_c1_en",    32'(timer_en),   32'd0);
    check("single_c1_busy",  32'(bus.busy),   32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("single_count", 32'(timer_out), 32'(5 - i));
      check("single_run_en", 32'(timer_en), 32'd1);
    end
    step();
    check("single_c8_done",  32'(bus.done),  32'd1);
    check("single_c8_grant", 32'(bus.grant), 32'd0);
    check("single_c8_en",    32'(timer_en),  32'd0);
    bus.req = 2'b00;
    step();
    check_idle("single_c9");

    // Zero interval: requester 1
    bus.req_init = {4'd0, 4'd0};
    bus.req      = 2'b10;
    step();
    check("zero_c1_load",  32'(timer_load), 32'd1);
    check("zero_c1_grant", 32'(bus.grant),  32'd2);
    check("zero_c1_init",  32'(timer_init), 32'd0);
    step();
    check("zero_c2_en",    32'(timer_en),  32'd1);
    check("zero_c2_tout",  32'(timer_out), 32'd0);
    check("zero_c2_done",  32'(bus.done),  32'd0);
    step();
    check("zero_c3_done",  32'(bus.done),  32'd2);
    bus.req = 2'b00;
    step();
    check_idle("zero_c4");

    // Fairness: both requesting, both interval 2
    bus.req_init = {4'd2, 4'd2};
    bus.req      = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic [31:0] exp_g;
      exp_g = (g % 2 == 0) ? 32'd1 : 32'd2;
      step();
      check("fair_grant", 32'(bus.grant), exp_g);
      check("fair_load",  32'(timer_load), 32'd1);
      repeat (3) step();
      check("fair_pre_done", 32'(bus.done), 32'd0);
      step();
      check("fair_done", 32'(bus.done), exp_g);
      if (g == 3) bus.req = 2'b00;
      step();
      check("fair_idle_busy",  32'(bus.busy),  32'd0);
      check("fair_idle_grant", 32'(bus.grant), 32'd0);
    end

    // Abort: requester 0, interval 9, drop req at cycle 4
    bus.req_init = {4'd1, 4'd9};
    bus.req      = 2'b01;
    step();
    check("abort_c1_grant", 32'(bus.grant), 32'd1);
    repeat (3) step();
    check("abort_c4_tout", 32'(timer_out), 32'd7);
    bus.req = 2'b00;
    step();
    check_idle("abort_c5");
    bus.req = 2'b11;
    step();
    check("abort_ptr_grant", 32'(bus.grant), 32'd2);
    check("abort_ptr_init",  32'(timer_init), 32'd1);
    bus.req = 2'b10;
    repeat (3) step();
    check("abort_next_done", 32'(bus.done), 32'd2);
    bus.req = 2'b00;
    step();
    check_idle("abort_end");

    // Contention: requester 1 arrives while requester 0 runs
    bus.req_init = {4'd2, 4'd3};
    bus.req      = 2'b01;
    step();
    check("cont_c1_grant", 32'(bus.grant), 32'd1);
    step();
    step();
    bus.req = 2'b11;
    check("cont_c3_grant", 32'(bus.grant), 32'd1);
    step();
    check("cont_c4_grant", 32'(bus.grant), 32'd1);
    step();
    check("cont_c5_tout",  32'(timer_out), 32'd0);
    step();
    check("cont_c6_done",  32'(bus.done),  32'd1);
    check("cont_c6_grant", 32'(bus.grant), 32'd0);
    bus.req = 2'b10;
    step();
    check("cont_c7_grant", 32'(bus.grant), 32'd0);
    check("cont_c7_busy",  32'(bus.busy),  32'd0);
    step();
    check("cont_c8_grant", 32'(bus.grant),  32'd2);
    check("cont_c8_init",  32'(timer_init), 32'd2);
    check("cont_c8_load",  32'(timer_load), 32'd1);
    step();
    check("cont_c9_tout",  32'(timer_out), 32'd2);
    check("cont_c9_en",    32'(timer_en),  32'd1);

    // Asynchronous reset mid-RUN
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    bus.req = 2'b00;
    repeat (2) step();
    check("async_rst_no_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    step();
    check_idle("async_rst_release");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares the single 4-bit down-counting `timer` between several requesters in the traffic-light design, such as the main phase controller and a pedestrian-crossing controller. Arbitration is round-robin. The block grants one requester at a time exclusive use of the timer and loads that requester's interval. It runs the count and signals completion to the owner. It sits between the requesting controllers and the `timer` instance, and owns `timer_en`, `timer_load` and `timer_init`.

## Interface
- `N_REQ`, 2, number of requesters.
- `TW`, 4, timer width; must match `timer`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  N_REQ  per-requester request level; held until `done` or abandoned.
- `req_init`  in  N_REQ*TW  interval per requester; slice i = `req_init[i*TW +: TW]`.
- `grant`  out  N_REQ  one-hot current owner; 0 when idle.
- `done`  out  N_REQ  one-cycle pulse to owner when its interval expires.
- `busy`  out  1  high in any state except IDLE.
- `timer_en`  out  1  decrement enable to `timer`.
- `timer_load`  out  1  load strobe to `timer`.
- `timer_init`  out  TW  load value to `timer`.
- `timer_out`  in  TW  current `timer` count.

## Operation
- Timer contract:
  - `timer_load` loads `timer_init` on the next edge; load wins over enable.
  - Otherwise `timer_en` decrements the count, saturating at 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any `req` bit is high, pick the winner with the round-robin picker, then go to LOAD.
  - The search starts at index `ptr`, then `ptr+1`, and so on, wrapping modulo N_REQ.
  - Register the winner's `grant` bit and `timer_init = req_init[winner]`.
- LOAD: `timer_load=1`, `timer_en=0`, `grant` held. Go to RUN.
- RUN:
  - `timer_en=1`, `grant` held.
  - If `timer_out==0`, go to DONE.
  - If the owner's `req` drops while `timer_out!=0`, abort: go to IDLE, clear `grant`, no `done` pulse.
  - Expiry takes priority over abort when both occur in the same cycle.
- DONE:
  - `done[owner]=1` for one cycle; `grant=0`, `timer_en=0`.
  - `ptr` moves to owner+1 (wrapping).
  - Go to IDLE.
- Abort also moves `ptr` to owner+1.
- `req_init` is sampled only in IDLE; later changes are ignored until the next grant.
- New requests that arrive while busy wait; they are never lost, since `req` is a level.
- `req_init` slice = 0: LOAD loads 0, RUN sees 0 immediately, then DONE.
- A requester that keeps `req` high after `done` is re-arbitrated. Round-robin gives the other requesters precedence.

## Timing
- All outputs are registered (Moore).
- Reset values: `grant=0`, `done=0`, `busy=0`, `timer_en=0`, `timer_load=0`, `timer_init=0`, state IDLE, `ptr=0`.
- Reset is asynchronous: outputs clear immediately when `rst` falls, including mid-RUN. The timer is reset separately.
- Request sampled in IDLE at edge k:
  - LOAD during cycle k+1.
  - RUN from k+2, with `timer_out=init` at k+2.
  - `timer_out` reaches 0 at k+2+init.
  - DONE (`done` pulse) at k+3+init.
  - IDLE at k+4+init.
- Minimum gap between consecutive grants is one IDLE cycle.

## Structure
- Shared package/header:
  - state encodings `ARB_IDLE=2'b00`, `ARB_LOAD=2'b01`, `ARB_RUN=2'b10`, `ARB_DONE=2'b11`;
  - default `TW`.
- Sub-module `rr_pick`: combinational round-robin priority picker (`req`, `ptr` → one-hot winner and winner index). Parameterised on N_REQ.
- Top level: state register, `ptr` register, owner index register, output registers.

## Test plan
Bench uses N_REQ=2, TW=4 and a real `timer` instance.
- Reset: hold `rst=0`, then release → all outputs 0 and `busy=0`. Pull `rst` low during RUN → outputs 0 immediately, no `done`.
- Single grant: `req=01`, `req_init[0]=5` sampled at edge 0 →
  - `grant=01` and `timer_load=1` with `timer_init=5` at cycle 1;
  - `timer_out` counts 5,4,3,2,1,0 over cycles 2–7;
  - `done=01` at cycle 8, `grant=00` at cycle 8.
- Zero interval: `req=10`, `req_init[1]=0` → LOAD at cycle 1, RUN at cycle 2, `done=10` at cycle 3.
- Fairness: `req=11` held continuously, both inits=2 → grants go 01, 10, 01, 10; each `done` arrives 5 cycles after its LOAD-1 sample.
- Abort: `req=01`, init=9; drop `req[0]` at cycle 4 → `grant=00` and `timer_en=0` at cycle 5, no `done`, `ptr=1`.
- Contention: `req[1]` raised at cycle 3 while requester 0 runs init=3 → `req[1]` waits; `grant=10` is issued in the cycle after DONE and the following IDLE sample.
